monitor_wb_gate: RTL and testbench
==================================

// Module: monitor_wb_gate
// PURPOSE
//  Wishbone write-protect and timeout gate placed directly upstream of the monitor RAM slave.
//  CPU-side bus (wbm_*) requests are registered and forwarded to the monitor RAM (wbs_*).
//  Writes arriving while write_lock=1 are terminated locally and never reach the RAM.
//  Blocked writes are counted and their addresses captured.
//  A hung downstream access is terminated after a cycle budget.
// PARAMETERS
//  TIMEOUT_CYCLES  255           max cycles wbs_stb_o stays high without wbs_ack_i; range 2..65535
//  CNT_W           8             width of violation counter; saturating
//  POISON          32'hDEADBEEF  wbm_dat_o value returned on timeout
// PORTS
//  sys_clk      in   1   system clock; all logic on rising edge
//  sys_rst_n    in   1   asynchronous active-low reset
//  write_lock   in   1   1 = monitor RAM is read-only
//  wbm_adr_i    in   32  upstream address
//  wbm_dat_i    in   32  upstream write data
//  wbm_sel_i    in   4   upstream byte selects
//  wbm_we_i     in   1   upstream write enable
//  wbm_cyc_i    in   1   upstream cycle
//  wbm_stb_i    in   1   upstream strobe
//  wbm_dat_o    out  32  read data to upstream, registered
//  wbm_ack_o    out  1   one-cycle termination pulse
//  wbm_err_o    out  1   error termination; constant 0 unless MONITOR_GATE_ERR_EN
//  wbs_adr_o    out  32  downstream address, held from acceptance
//  wbs_dat_o    out  32  downstream write data, held
//  wbs_sel_o    out  4   downstream byte selects, held
//  wbs_we_o     out  1   downstream write enable, held
//  wbs_cyc_o    out  1   downstream cycle
//  wbs_stb_o    out  1   downstream strobe
//  wbs_dat_i    in   32  downstream read data
//  wbs_ack_i    in   1   downstream acknowledge
//  viol_clr     in   1   synchronous clear of viol_cnt and viol_adr
//  viol_cnt     out  CNT_W  blocked-write count
//  viol_adr     out  32  address of most recent blocked write
// BEHAVIOUR
//  Reset: all outputs 0; FSM in IDLE; viol_cnt=0; viol_adr=0.
//  FSM states:
//   IDLE:
//    - On wbm_cyc_i & wbm_stb_i, latch adr/dat/sel/we and sample write_lock.
//    - Write with lock=1 -> BLOCK. Otherwise -> FWD.
//   FWD:
//    - wbs_cyc_o=wbs_stb_o=1; timer runs.
//    - On wbs_ack_i: capture wbs_dat_i into wbm_dat_o -> RESP.
//    - On timer reaching TIMEOUT_CYCLES: wbm_dat_o=POISON -> RESP.
//   BLOCK:
//    - Drive no downstream signals.
//    - viol_adr <= latched address; viol_cnt++ (saturating at 2^CNT_W-1).
//    - -> RESP.
//   RESP:
//    - wbm_ack_o=1 (or wbm_err_o, see CONFIGURATION) for exactly one cycle -> IDLE.
//  Latency:
//   - Accepted at edge N; wbs_stb_o high from N+1.
//   - Downstream ack at cycle M gives upstream ack in cycle M+1.
//   - Blocked write gives ack in cycle N+2.
//  write_lock is sampled only at acceptance; a toggle mid-transfer does not affect the in-flight access.
//  Upstream abort (wbm_cyc_i=0 in FWD or BLOCK):
//   - Drop wbs_cyc_o/wbs_stb_o next cycle; return to IDLE; no ack.
//   - A blocked write that was already accepted is still counted.
//  A stray wbs_ack_i outside FWD is ignored.
//  viol_clr in the same cycle as a BLOCK increment: viol_cnt=1 and viol_adr=new address.
//  wbm_sel_i=0 writes are still gated and counted.
// CONFIGURATION
//  MONITOR_GATE_ERR_EN defined:
//   - Blocked writes and timeouts terminate with wbm_err_o=1, wbm_ack_o=0.
//  MONITOR_GATE_ERR_EN undefined:
//   - Both terminate with wbm_ack_o=1.
//   - wbm_err_o is tied 0.
// STRUCTURE
//  monitor_gate_defs.v (shared include): FSM state encodings IDLE=2'd0, FWD=2'd1, BLOCK=2'd2, RESP=2'd3;
//   default POISON constant.
//  Sub-module monitor_gate_timer: 16-bit counter.
//   - Inputs: clear, enable.
//   - Output: expire pulse at TIMEOUT_CYCLES.
// TESTING
//  lock=0; write 0x0000_0010 <= 0x1234_5678; RAM acks after 1 cycle -> RAM word updated; wbm_ack_o one pulse;
//   viol_cnt=0.
//  lock=1; write 0x0000_0020 -> wbs_stb_o never rises; ack at accept+2; viol_cnt=1; viol_adr=0x20; RAM unchanged.
//  lock=1; read 0x0000_0010 -> forwarded; wbm_dat_o=0x1234_5678.
//  TIMEOUT_CYCLES=4; RAM never acks -> wbs_stb_o high exactly 4 cycles; wbm_dat_o=0xDEADBEEF;
//   err (ERR_EN) or ack.
//  CNT_W=2; 5 blocked writes -> viol_cnt saturates at 3; viol_clr together with 6th -> viol_cnt=1.
//  Abort: drop wbm_cyc_i 1 cycle into FWD -> wbs_cyc_o=0 next cycle; no ack.
//  Abort: sys_rst_n low mid-FWD -> all outputs 0 immediately.

Source files
------------

// File: rtl/monitor_wb_gate_pkg.sv
// -----------------------------------------------------------------------------
// monitor_wb_gate_pkg
// Shared definitions for the monitor RAM write-protect / timeout gate.
//   gateState_e    : gate FSM state encoding (IDLE, FWD, BLOCK, RESP)
//   DEFAULT_POISON : read data returned upstream when a downstream access hangs
//   TIMER_W        : width of the hang-detection counter
// -----------------------------------------------------------------------------
package monitor_wb_gate_pkg;

   typedef enum logic [1:0] {
      IDLE  = 2'd0,
      FWD   = 2'd1,
      BLOCK = 2'd2,
      RESP  = 2'd3
   } gateState_e;

   localparam logic [31:0] DEFAULT_POISON = 32'hDEADBEEF;
   localparam int          TIMER_W        = 16;

endpackage

// File: rtl/monitor_wb_gate_if.sv
// -----------------------------------------------------------------------------
// monitor_wb_gate_if
// Classic Wishbone bus bundle used on both sides of the gate.
//   adr, datW, sel, we, cyc, stb : request, driven by the bus master
//   datR, ack                    : response, driven by the bus slave
//   err                          : error termination, driven by the slave; the
//                                  master modport leaves it out because the
//                                  monitor RAM has no error line
// -----------------------------------------------------------------------------
interface monitor_wb_gate_if;

   logic [31:0] adr;
   logic [31:0] datW;
   logic [31:0] datR;
   logic [3:0]  sel;
   logic        we;
   logic        cyc;
   logic        stb;
   logic        ack;
   logic        err;

   modport master (
      output adr, datW, sel, we, cyc, stb,
      input  datR, ack
   );

   modport slave (
      input  adr, datW, sel, we, cyc, stb,
      output datR, ack, err
   );

endinterface

// File: rtl/monitor_wb_gate_timer.sv
// -----------------------------------------------------------------------------
// monitor_wb_gate_timer
// Hang-detection counter for a forwarded access.
//   sys_clk, sys_rst_n : clock, asynchronous active-low reset
//   clear_i            : return the count to zero (held while no access runs)
//   enable_i           : count one cycle of an outstanding downstream strobe
//   expire_o           : high in the TIMEOUT_CYCLES-th enabled cycle
// -----------------------------------------------------------------------------
module monitor_wb_gate_timer
   import monitor_wb_gate_pkg::*;
#(
   parameter int unsigned TIMEOUT_CYCLES = 255
) (
   input  logic sys_clk,
   input  logic sys_rst_n,
   input  logic clear_i,
   input  logic enable_i,
   output logic expire_o
);

   localparam logic [TIMER_W-1:0] LAST = TIMER_W'(TIMEOUT_CYCLES - 1);

   logic [TIMER_W-1:0] count_q;

   // The count equals the number of strobe cycles already completed, so the
   // cycle in which it reads LAST is the final one the access is allowed.
   always_ff @(posedge sys_clk or negedge sys_rst_n) begin
      if (!sys_rst_n) begin
         count_q <= '0;
      end else if (clear_i) begin
         count_q <= '0;
      end else if (enable_i) begin
         count_q <= count_q + TIMER_W'(1);
      end
   end

   assign expire_o = enable_i && (count_q == LAST);

endmodule

// File: rtl/monitor_wb_gate.sv
// -----------------------------------------------------------------------------
// monitor_wb_gate
// Write-protect and timeout gate placed in front of the monitor RAM slave.
// Upstream requests are latched and forwarded downstream; writes taken while
// write_lock is high are terminated locally, counted and their address kept.
// A downstream access that is never acknowledged is ended after
// TIMEOUT_CYCLES strobe cycles with POISON as read data.
//
// Ports
//   sys_clk, sys_rst_n : clock, asynchronous active-low reset
//   write_lock         : 1 = monitor RAM is read-only (sampled at acceptance)
//   wbm                : upstream (CPU side) bus, this block is the slave
//   wbs                : downstream (monitor RAM) bus, this block is the master
//   viol_clr           : synchronous clear of viol_cnt / viol_adr
//   viol_cnt           : saturating count of blocked writes
//   viol_adr           : address of the most recent blocked write
//
// Build option
//   MONITOR_GATE_ERR_EN : blocked writes and timeouts end with wbm.err instead
//                         of wbm.ack; when undefined wbm.err is tied low.
// -----------------------------------------------------------------------------
module monitor_wb_gate
   import monitor_wb_gate_pkg::*;
#(
   parameter int unsigned TIMEOUT_CYCLES = 255,
   parameter int unsigned CNT_W          = 8,
   parameter logic [31:0] POISON         = DEFAULT_POISON
) (
   input  logic              sys_clk,
   input  logic              sys_rst_n,
   input  logic              write_lock,
   monitor_wb_gate_if.slave  wbm,
   monitor_wb_gate_if.master wbs,
   input  logic              viol_clr,
   output logic [CNT_W-1:0]  viol_cnt,
   output logic [31:0]       viol_adr
);

`ifdef MONITOR_GATE_ERR_EN
   localparam logic ERR_RESP = 1'b1;
`else
   localparam logic ERR_RESP = 1'b0;
`endif
   localparam logic [CNT_W-1:0] CNT_MAX = '1;

   gateState_e       state_q, state_d;
   logic [31:0]      adr_q, dat_q;
   logic [3:0]       sel_q;
   logic             we_q;
   logic [31:0]      rdat_q, rdat_d;
   logic             errResp_q, errResp_d;
   logic [CNT_W-1:0] violCnt_q;
   logic [31:0]      violAdr_q;
   logic             accept, countViol, timerClr, timerEn, expire;

   monitor_wb_gate_timer #(
      .TIMEOUT_CYCLES(TIMEOUT_CYCLES)
   ) uTimer (
      .sys_clk  (sys_clk),
      .sys_rst_n(sys_rst_n),
      .clear_i  (timerClr),
      .enable_i (timerEn),
      .expire_o (expire)
   );

   // State, response data and the "terminate with error" flag all move
   // together; the response data stays put between transfers.
   always_ff @(posedge sys_clk or negedge sys_rst_n) begin
      if (!sys_rst_n) begin
         state_q   <= IDLE;
         rdat_q    <= '0;
         errResp_q <= 1'b0;
      end else begin
         state_q   <= state_d;
         rdat_q    <= rdat_d;
         errResp_q <= errResp_d;
      end
   end

   // The request is captured once at acceptance and then held for the whole
   // transfer so upstream may change its lines without disturbing the RAM.
   always_ff @(posedge sys_clk or negedge sys_rst_n) begin
      if (!sys_rst_n) begin
         adr_q <= '0;
         dat_q <= '0;
         sel_q <= '0;
         we_q  <= 1'b0;
      end else if (accept) begin
         adr_q <= wbm.adr;
         dat_q <= wbm.datW;
         sel_q <= wbm.sel;
         we_q  <= wbm.we;
      end
   end

   // A blocked write always counts once BLOCK is reached, even if upstream
   // aborts. A clear arriving in that same cycle restarts the count at one so
   // the new violation is not lost.
   always_ff @(posedge sys_clk or negedge sys_rst_n) begin
      if (!sys_rst_n) begin
         violCnt_q <= '0;
         violAdr_q <= '0;
      end else if (countViol) begin
         violAdr_q <= adr_q;
         if (viol_clr) begin
            violCnt_q <= CNT_W'(1);
         end else if (violCnt_q != CNT_MAX) begin
            violCnt_q <= violCnt_q + CNT_W'(1);
         end
      end else if (viol_clr) begin
         violCnt_q <= '0;
         violAdr_q <= '0;
      end
   end

   // Next-state logic. Within FWD an upstream abort outranks a downstream
   // ack, which in turn outranks the timeout. write_lock only matters in IDLE.
   always_comb begin
      state_d   = state_q;
      rdat_d    = rdat_q;
      errResp_d = errResp_q;
      accept    = 1'b0;
      countViol = 1'b0;
      timerClr  = 1'b1;
      timerEn   = 1'b0;
      unique case (state_q)
         IDLE: begin
            if (wbm.cyc && wbm.stb) begin
               accept  = 1'b1;
               state_d = (wbm.we && write_lock) ? BLOCK : FWD;
            end
         end
         FWD: begin
            timerClr = 1'b0;
            timerEn  = 1'b1;
            if (!wbm.cyc) begin
               state_d = IDLE;
            end else if (wbs.ack) begin
               rdat_d    = wbs.datR;
               errResp_d = 1'b0;
               state_d   = RESP;
            end else if (expire) begin
               rdat_d    = POISON;
               errResp_d = ERR_RESP;
               state_d   = RESP;
            end
         end
         BLOCK: begin
            countViol = 1'b1;
            if (!wbm.cyc) begin
               state_d = IDLE;
            end else begin
               errResp_d = ERR_RESP;
               state_d   = RESP;
            end
         end
         RESP: begin
            state_d = IDLE;
         end
         default: begin
            state_d = IDLE;
         end
      endcase
   end

   // Downstream lines are only driven while an access is actually forwarded.
   assign wbs.cyc  = (state_q == FWD);
   assign wbs.stb  = (state_q == FWD);
   assign wbs.adr  = (state_q == FWD) ? adr_q : '0;
   assign wbs.datW = (state_q == FWD) ? dat_q : '0;
   assign wbs.sel  = (state_q == FWD) ? sel_q : '0;
   assign wbs.we   = (state_q == FWD) && we_q;

   assign wbm.datR = rdat_q;
   assign wbm.ack  = (state_q == RESP) && !errResp_q;
`ifdef MONITOR_GATE_ERR_EN
   assign wbm.err  = (state_q == RESP) && errResp_q;
`else
   assign wbm.err  = 1'b0;
`endif

   assign viol_cnt = violCnt_q;
   assign viol_adr = violAdr_q;

endmodule

// File: tb/tb_monitor_wb_gate.sv
// -----------------------------------------------------------------------------
// tb_monitor_wb_gate
// Bench for monitor_wb_gate with TIMEOUT_CYCLES=4 and CNT_W=2. A word RAM in
// the bench answers the downstream bus; a second copy tracks what the RAM
// should hold. Expected per-cycle outputs come from the transaction rules.
// -----------------------------------------------------------------------------
module tb_monitor_wb_gate;

   localparam int          TO      = 4;
   localparam int          CW      = 2;
   localparam int          CNT_MAX = (1 << CW) - 1;
   localparam logic [31:0] POISON  = 32'hDEADBEEF;
`ifdef MONITOR_GATE_ERR_EN
   localparam bit ERR_EN = 1'b1;
`else
   localparam bit ERR_EN = 1'b0;
`endif

   logic          sysClk;
   logic          sysRstN;
   logic          writeLock;
   logic          violClr;
   logic [CW-1:0] violCnt;
   logic [31:0]   violAdr;

   monitor_wb_gate_if wbm();
   monitor_wb_gate_if wbs();

   monitor_wb_gate #(
      .TIMEOUT_CYCLES(TO),
      .CNT_W         (CW),
      .POISON        (POISON)
   ) dut (
      .sys_clk   (sysClk),
      .sys_rst_n (sysRstN),
      .write_lock(writeLock),
      .wbm       (wbm),
      .wbs       (wbs),
      .viol_clr  (violClr),
      .viol_cnt  (violCnt),
      .viol_adr  (violAdr)
   );

   initial sysClk = 1'b0;
   always #5 sysClk = ~sysClk;

   int total = 0;
   int bad   = 0;

   bit          chkEn = 1'b0;
   bit          expStb = 1'b0, expAck = 1'b0, expErr = 1'b0, expDatValid = 1'b0;
   logic [31:0] expDat = '0;
   int          expCnt = 0;
   logic [31:0] expVAdr = '0;
   logic [31:0] expReqAdr = '0, expReqDat = '0;
   logic [3:0]  expReqSel = '0;
   logic        expReqWe = 1'b0;

   logic [31:0] ramDut [64];
   logic [31:0] ramRef [64];

   task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
      total++;
      if (act !== exp) begin
         bad++;
         $display("[TB] FAIL %s actual=%h required=%h at %0t", name, act, exp, $time);
      end
   endtask

   function automatic logic [31:0] mergeBytes(input logic [31:0] old, input logic [31:0] nw,
                                              input logic [3:0] sel);
      logic [31:0] r;
      r = old;
      for (int b = 0; b < 4; b++) begin
         if (sel[b]) r[8*b +: 8] = nw[8*b +: 8];
      end
      return r;
   endfunction

   // Every cycle, mid-period, compare the DUT against the expected values.
   always @(negedge sysClk) begin
      if (chkEn) begin
         checkOutput("wbs_stb", 32'(wbs.stb), 32'(expStb));
         checkOutput("wbs_cyc", 32'(wbs.cyc), 32'(expStb));
         checkOutput("wbm_ack", 32'(wbm.ack), 32'(expAck));
         checkOutput("wbm_err", 32'(wbm.err), 32'(expErr));
         checkOutput("viol_cnt", 32'(violCnt), 32'(expCnt));
         checkOutput("viol_adr", violAdr, expVAdr);
         if (expStb) begin
            checkOutput("wbs_adr", wbs.adr, expReqAdr);
            checkOutput("wbs_sel", 32'(wbs.sel), 32'(expReqSel));
            checkOutput("wbs_we", 32'(wbs.we), 32'(expReqWe));
            if (expReqWe) checkOutput("wbs_dat", wbs.datW, expReqDat);
         end
         if (expDatValid) checkOutput("wbm_dat", wbm.datR, expDat);
      end
   end

   task automatic nextCycle();
      @(posedge sysClk);
      #1;
   endtask

   task automatic idleCycles(input int n, input bit forceClr, input bit randClr);
      for (int i = 0; i < n; i++) begin
         wbs.ack = 1'($urandom_range(0, 1));
         violClr = forceClr || (randClr && ($urandom_range(0, 7) == 0));
         nextCycle();
         if (violClr) begin
            expCnt  = 0;
            expVAdr = '0;
         end
         violClr = 1'b0;
         wbs.ack = 1'b0;
      end
   endtask

   // One upstream transaction. lat: downstream ack in that strobe cycle
   // (beyond TO = never). abortAt: upstream drops cyc in that cycle (0 = never).
   task automatic applyStimulus(input logic we, input logic [5:0] idx, input logic [31:0] dat,
                                input logic [3:0] sel, input logic lock, input int lat,
                                input int abortAt, input logic clr,
                                output logic [31:0] rdat, output int stbCnt, output logic acked);
      logic [31:0] adr;
      logic [31:0] oldWord;
      bit          done;
      adr     = {24'd0, idx, 2'b00};
      rdat    = '0;
      stbCnt  = 0;
      acked   = 1'b0;
      oldWord = '0;
      expStb = 1'b0; expAck = 1'b0; expErr = 1'b0; expDatValid = 1'b0;
      expReqAdr = adr; expReqDat = dat; expReqSel = sel; expReqWe = we;
      wbm.adr = adr; wbm.datW = dat; wbm.sel = sel; wbm.we = we;
      wbm.cyc = 1'b1; wbm.stb = 1'b1;
      writeLock = lock;
      wbs.ack = 1'b0;
      nextCycle();
      writeLock = 1'($urandom_range(0, 1));
      if (we && lock) begin
         violClr = clr;
         if (abortAt != 0) begin
            wbm.cyc = 1'b0; wbm.stb = 1'b0;
         end
         if (wbs.stb) stbCnt++;
         nextCycle();
         violClr = 1'b0;
         expCnt  = clr ? 1 : ((expCnt < CNT_MAX) ? expCnt + 1 : CNT_MAX);
         expVAdr = adr;
         if (abortAt == 0) begin
            acked  = 1'b1;
            expAck = !ERR_EN;
            expErr = ERR_EN;
         end
      end else begin
         done = 1'b0;
         for (int j = 1; j <= TO && !done; j++) begin
            expStb   = 1'b1;
            wbs.ack  = (j == lat);
            wbs.datR = ramDut[wbs.adr[7:2]];
            if (j == abortAt) begin
               wbm.cyc = 1'b0; wbm.stb = 1'b0;
            end
            if (wbs.stb) begin
               stbCnt++;
               if (wbs.ack && wbs.we)
                  ramDut[wbs.adr[7:2]] = mergeBytes(ramDut[wbs.adr[7:2]], wbs.datW, wbs.sel);
            end
            if (j == lat) begin
               oldWord = ramRef[idx];
               if (we) ramRef[idx] = mergeBytes(ramRef[idx], dat, sel);
            end
            nextCycle();
            wbs.ack = 1'b0;
            if (j == abortAt) begin
               done = 1'b1;
            end else if (j == lat) begin
               done = 1'b1; acked = 1'b1;
               expAck = 1'b1; expDat = oldWord; expDatValid = 1'b1;
            end else if (j == TO) begin
               done = 1'b1; acked = 1'b1;
               expAck = !ERR_EN; expErr = ERR_EN; expDat = POISON; expDatValid = 1'b1;
            end
            if (done) expStb = 1'b0;
         end
      end
      wbm.cyc = 1'b0; wbm.stb = 1'b0;
      if (acked) rdat = wbm.datR;
      nextCycle();
      expAck = 1'b0; expErr = 1'b0; expDatValid = 1'b0;
   endtask

   initial begin
      logic [31:0] rd;
      int          sc;
      logic        ak;
      logic        rWe, rLock, rClr;
      logic [5:0]  rIdx;
      logic [31:0] rDat;
      logic [3:0]  rSel;
      int          rLat, rAbort;

      for (int i = 0; i < 64; i++) begin
         ramDut[i] = '0;
         ramRef[i] = '0;
      end
      sysRstN = 1'b1; writeLock = 1'b0; violClr = 1'b0;
      wbm.adr = '0; wbm.datW = '0; wbm.sel = '0; wbm.we = 1'b0; wbm.cyc = 1'b0; wbm.stb = 1'b0;
      wbs.datR = '0; wbs.ack = 1'b0; wbs.err = 1'b0;
      #1 sysRstN = 1'b0;
      #2;
      checkOutput("rst_wbs_stb", 32'(wbs.stb), 32'h0);
      checkOutput("rst_wbs_cyc", 32'(wbs.cyc), 32'h0);
      checkOutput("rst_wbs_adr", wbs.adr, 32'h0);
      checkOutput("rst_wbm_ack", 32'(wbm.ack), 32'h0);
      checkOutput("rst_wbm_dat", wbm.datR, 32'h0);
      checkOutput("rst_viol_cnt", 32'(violCnt), 32'h0);
      checkOutput("rst_viol_adr", violAdr, 32'h0);
      nextCycle();
      nextCycle();
      sysRstN = 1'b1;
      chkEn   = 1'b1;
      idleCycles(2, 1'b0, 1'b0);

      applyStimulus(1'b1, 6'h04, 32'h1234_5678, 4'hF, 1'b0, 1, 0, 1'b0, rd, sc, ak);
      checkOutput("t1_ram_word", ramDut[4], 32'h1234_5678);
      checkOutput("t1_viol_cnt", 32'(violCnt), 32'h0);
      checkOutput("t1_acked", 32'(ak), 32'h1);

      applyStimulus(1'b1, 6'h08, 32'hCAFE_F00D, 4'hF, 1'b1, 1, 0, 1'b0, rd, sc, ak);
      checkOutput("t2_stb_cycles", 32'(sc), 32'h0);
      checkOutput("t2_viol_cnt", 32'(violCnt), 32'h1);
      checkOutput("t2_viol_adr", violAdr, 32'h20);
      checkOutput("t2_ram_word", ramDut[8], 32'h0);

      applyStimulus(1'b0, 6'h04, 32'h0, 4'hF, 1'b1, 2, 0, 1'b0, rd, sc, ak);
      checkOutput("t3_read_data", rd, 32'h1234_5678);

      applyStimulus(1'b0, 6'h0C, 32'h0, 4'hF, 1'b0, TO + 1, 0, 1'b0, rd, sc, ak);
      checkOutput("t4_stb_cycles", 32'(sc), 32'h4);
      checkOutput("t4_poison", rd, 32'hDEAD_BEEF);

      idleCycles(1, 1'b1, 1'b0);
      for (int k = 0; k < 5; k++)
         applyStimulus(1'b1, 6'(6'h10 + k), 32'(k), 4'h0, 1'b1, 1, 0, 1'b0, rd, sc, ak);
      checkOutput("t5_saturated", 32'(violCnt), 32'h3);
      applyStimulus(1'b1, 6'h15, 32'h0, 4'hF, 1'b1, 1, 0, 1'b1, rd, sc, ak);
      checkOutput("t5_clr_with_block", 32'(violCnt), 32'h1);
      checkOutput("t5_clr_adr", violAdr, 32'h54);

      applyStimulus(1'b0, 6'h03, 32'h0, 4'hF, 1'b0, TO + 1, 2, 1'b0, rd, sc, ak);
      checkOutput("t6_abort_noack", 32'(ak), 32'h0);
      checkOutput("t6_abort_stb_cycles", 32'(sc), 32'h2);

      applyStimulus(1'b1, 6'h09, 32'h5, 4'hF, 1'b1, 1, 1, 1'b0, rd, sc, ak);
      checkOutput("t7_block_abort_noack", 32'(ak), 32'h0);
      checkOutput("t7_block_abort_cnt", 32'(violCnt), 32'h2);
      checkOutput("t7_block_abort_adr", violAdr, 32'h24);

      expReqAdr = 32'h40; expReqSel = 4'hF; expReqWe = 1'b0;
      wbm.adr = 32'h40; wbm.sel = 4'hF; wbm.we = 1'b0; wbm.cyc = 1'b1; wbm.stb = 1'b1;
      writeLock = 1'b0;
      nextCycle();
      expStb = 1'b1;
      nextCycle();
      #1;
      chkEn   = 1'b0;
      sysRstN = 1'b0;
      #1;
      checkOutput("t8_rst_stb", 32'(wbs.stb), 32'h0);
      checkOutput("t8_rst_cyc", 32'(wbs.cyc), 32'h0);
      checkOutput("t8_rst_ack", 32'(wbm.ack), 32'h0);
      checkOutput("t8_rst_dat", wbm.datR, 32'h0);
      checkOutput("t8_rst_cnt", 32'(violCnt), 32'h0);
      checkOutput("t8_rst_adr", violAdr, 32'h0);
      wbm.cyc = 1'b0; wbm.stb = 1'b0;
      expStb = 1'b0; expCnt = 0; expVAdr = '0;
      nextCycle();
      sysRstN = 1'b1;
      chkEn   = 1'b1;
      idleCycles(1, 1'b0, 1'b0);

      for (int t = 0; t < 200; t++) begin
         rWe    = 1'($urandom_range(0, 1));
         rIdx   = 6'($urandom_range(0, 63));
         rDat   = $urandom();
         rSel   = ($urandom_range(0, 7) == 0) ? 4'h0 : 4'($urandom_range(0, 15));
         rLock  = 1'($urandom_range(0, 1));
         rLat   = $urandom_range(1, TO + 1);
         rAbort = ($urandom_range(0, 7) == 0) ? int'($urandom_range(1, TO)) : 0;
         rClr   = ($urandom_range(0, 4) == 0);
         applyStimulus(rWe, rIdx, rDat, rSel, rLock, rLat, rAbort, rClr, rd, sc, ak);
         idleCycles($urandom_range(0, 2), 1'b0, 1'b1);
      end

      for (int i = 0; i < 64; i++) checkOutput("ram_contents", ramDut[i], ramRef[i]);

      chkEn = 1'b0;
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
